// File: rtl/sdp_mem_rd_arbiter.sv
// sdp_mem_rd_arbiter
//   Read-port controller for the simple dual-port memory. It shares port B
//   between NUM_REQ requesters and issues at most one read per cycle. It
//   tracks the memory's fixed LATENCY-cycle read pipeline and returns read
//   data in issue order on one tagged response stream.
//   A small response FIFO with credit-based issue keeps back-pressure on the
//   response stream lossless.
//
//   Build option:
//     SDP_RD_ARB_ROUND_ROBIN_EN  defined     -> round-robin arbitration
//                                undefined   -> fixed priority (lowest index wins)
//
//   Ports:
//     clk        clock, also drives the memory clkb
//     rstn       asynchronous active-low reset
//     req_valid  per-requester read request
//     req_ready  one-hot grant (handshake = req_valid[i] & req_ready[i])
//     req_addr   packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//     rsp_valid  response available
//     rsp_ready  response consumer ready
//     rsp_data   read word
//     rsp_id     index of the requester that issued the read
//     mem_addrb  memory addrb
//     mem_enb    memory enb (output-register enable)
//     mem_doutb  memory doutb
module sdp_mem_rd_arbiter #(
  parameter  int NUM_REQ    = 2,
  parameter  int DEPTH      = 169,
  parameter  int DATA_WIDTH = 32,
  parameter  int LATENCY    = 2,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [ADDR_WIDTH-1:0]         mem_addrb,
  output logic                          mem_enb,
  input  logic [DATA_WIDTH-1:0]         mem_doutb
);

  localparam int RSP_DEPTH = LATENCY + 2;
  localparam int PTR_W     = $clog2(RSP_DEPTH);
  localparam int CNT_W     = $clog2(RSP_DEPTH + 1);

  logic [LATENCY-1:0]    pipe_vld;
  logic [ID_WIDTH-1:0]   pipe_id [LATENCY];

  logic [DATA_WIDTH-1:0] fifo_data [RSP_DEPTH];
  logic [ID_WIDTH-1:0]   fifo_id   [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_push;
  logic                  fifo_pop;

  logic                  issue_ok;
  logic                  any_grant;
  logic [ID_WIDTH-1:0]   gnt_idx;
  logic [NUM_REQ-1:0]    grant;
  int                    inflight;

  // Credit check: every read already in the pipeline has a FIFO slot
  // reserved. A pop in this same cycle is deliberately not credited.
  // Issue is also blocked while rstn is low so that all outputs are
  // quiet for the whole reset.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < LATENCY; i++) begin
      if (pipe_vld[i]) inflight++;
    end
    issue_ok = rstn && ((int'(fifo_count) + inflight) < RSP_DEPTH);
  end

`ifdef SDP_RD_ARB_ROUND_ROBIN_EN
  // rr_ptr holds the index the search starts from (last granted + 1).
  logic [ID_WIDTH-1:0] rr_ptr;

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    gnt_idx   = '0;
    any_grant = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (issue_ok && !any_grant && req_valid[idx]) begin
        any_grant  = 1'b1;
        gnt_idx    = ID_WIDTH'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr <= '0;
    end else if (any_grant) begin
      rr_ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + ID_WIDTH'(1);
    end
  end
`else
  always_comb begin
    grant     = '0;
    gnt_idx   = '0;
    any_grant = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (issue_ok && !any_grant && req_valid[k]) begin
        any_grant = 1'b1;
        gnt_idx   = ID_WIDTH'(k);
        grant[k]  = 1'b1;
      end
    end
  end
`endif

  assign req_ready = grant;

  always_comb begin
    mem_addrb = '0;
    if (any_grant) mem_addrb = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // In-flight tracker: one {valid, id} per memory pipeline stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pipe_vld <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_id[i] <= '0;
    end else begin
      pipe_vld   <= {pipe_vld[LATENCY-2:0], any_grant};
      pipe_id[0] <= gnt_idx;
      for (int i = 1; i < LATENCY; i++) pipe_id[i] <= pipe_id[i-1];
    end
  end

  // The memory output register is enabled only in the cycle in which a
  // tracked read reaches it. At other times doutb holds and is ignored.
  assign mem_enb   = pipe_vld[LATENCY-2];
  assign fifo_push = pipe_vld[LATENCY-1];
  assign rsp_valid = (fifo_count != '0);
  assign fifo_pop  = rsp_valid & rsp_ready;

  // The FIFO storage is not reset. The outputs are masked while the FIFO
  // is empty, so stale contents never become visible.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_data[wr_ptr] <= mem_doutb;
      fifo_id[wr_ptr]   <= pipe_id[LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr <= (int'(wr_ptr) == RSP_DEPTH - 1) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (fifo_pop) begin
        rd_ptr <= (int'(rd_ptr) == RSP_DEPTH - 1) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign rsp_data = rsp_valid ? fifo_data[rd_ptr] : '0;
  assign rsp_id   = rsp_valid ? fifo_id[rd_ptr]   : '0;

  // The credit rule must make a push into a full FIFO impossible.
  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!rstn)
      !(fifo_push && (int'(fifo_count) == RSP_DEPTH))
  );

endmodule
